// File: rtl/neuron_mac_seq.sv
// Single-neuron forward-pass sequencer: bias + sum(w*x) on a shared Q16.16
// multiply/accumulate path with a one-stage product register, then relu.
// Produces activation, pre-activation and relu derivative over valid/ready.
module neuron_mac_seq #(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          start_ready,
   input  logic [DW-1:0] bias,
   input  logic          act_en,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_x,
   input  logic [DW-1:0] in_w,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_y,
   output logic [DW-1:0] out_pre,
   output logic          out_d,
   output logic [CW-1:0] out_count
);

   typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

   state_e        state_q;
   logic [DW-1:0] acc_q;
   logic [DW-1:0] prod_r_q;
   logic          prod_v_q;
   logic          act_en_q;
   logic [CW-1:0] count_q;
   logic [DW-1:0] out_y_q;
   logic [DW-1:0] out_pre_q;
   logic          out_d_q;
   logic          out_valid_q;

   logic signed [2*DW-1:0] prod_full;
   logic [DW-1:0]          mult_res;
   logic [DW-1:0]          acc_sum;
   logic                   sum_pos;
   logic                   beat;
   logic                   unused_prod_bits;

   // Q16.16 product: keep bits [47:16], round half up on bit 15.
   always_comb begin
      prod_full = $signed(in_x) * $signed(in_w);
      mult_res  = prod_full[DW+15:16] + DW'(prod_full[15]);
      acc_sum   = acc_q + (prod_v_q ? prod_r_q : '0);
      sum_pos   = $signed(acc_sum) > 0;
      beat      = in_valid && (state_q == StAccum);
   end

   assign unused_prod_bits = ^{prod_full[2*DW-1:DW+16], prod_full[14:0]};

   assign start_ready = (state_q == StIdle);
   assign in_ready    = (state_q == StAccum);
   assign out_valid   = out_valid_q;
   assign out_y       = out_y_q;
   assign out_pre     = out_pre_q;
   assign out_d       = out_d_q;
   assign out_count   = count_q;

   // Sequencer FSM with the accumulate datapath and registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         prod_r_q    <= '0;
         prod_v_q    <= 1'b0;
         act_en_q    <= 1'b0;
         count_q     <= '0;
         out_y_q     <= '0;
         out_pre_q   <= '0;
         out_d_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  acc_q    <= bias;
                  act_en_q <= act_en;
                  count_q  <= '0;
                  prod_v_q <= 1'b0;
                  state_q  <= StAccum;
               end
            end
            StAccum: begin
               // Pending product is folded in every cycle, even during gaps.
               acc_q    <= acc_sum;
               prod_r_q <= mult_res;
               prod_v_q <= beat;
               count_q  <= count_q + CW'(beat);
               if (beat && in_last) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               acc_q       <= acc_sum;
               prod_v_q    <= 1'b0;
               out_pre_q   <= acc_sum;
               out_y_q     <= (!act_en_q || sum_pos) ? acc_sum : '0;
               out_d_q     <= !act_en_q || sum_pos;
               out_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: directed vectors push expected results,
// a monitor pops and compares whenever the DUT presents a result.
module tb_neuron_mac_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start_ready;
   logic [31:0] bias = '0;
   logic        act_en = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = '0;
   logic [31:0] in_w = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_y;
   logic [31:0] out_pre;
   logic        out_d;
   logic [15:0] out_count;

   neuron_mac_seq #(.DW(32), .CW(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_ready(start_ready),
      .bias       (bias),
      .act_en     (act_en),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_w       (in_w),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_pre    (out_pre),
      .out_d      (out_d),
      .out_count  (out_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pre;
      logic [31:0] y;
      logic        d;
      logic [15:0] cnt;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: pop on each new result, then check it stays stable until accepted.
   initial begin
      exp_t        e;
      logic        holding = 1'b0;
      logic [31:0] cap_pre, cap_y;
      logic        cap_d;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            holding = 1'b0;
         end else if (out_valid) begin
            if (!holding) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out_valid", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk("out_pre", 64'(out_pre), 64'(e.pre));
                  chk("out_y", 64'(out_y), 64'(e.y));
                  chk("out_d", 64'(out_d), 64'(e.d));
                  chk("out_count", 64'(out_count), 64'(e.cnt));
                  chk("latency_cycle", 64'(cyc), 64'(e.at));
               end
               cap_pre = out_pre;
               cap_y   = out_y;
               cap_d   = out_d;
               holding = 1'b1;
            end else begin
               chk("stable_pre", 64'(out_pre), 64'(cap_pre));
               chk("stable_y", 64'(out_y), 64'(cap_y));
               chk("stable_d", 64'(out_d), 64'(cap_d));
            end
            if (out_ready) holding = 1'b0;
         end
      end
   end

   // Beat table for the current vector.
   logic [31:0] bx[8], bw[8];
   logic        bv[8], bl[8], bs[8];
   int          nb;
   int          last_cyc;

   task automatic set_beat(input int i, input logic v, input logic l,
                           input logic [31:0] x, input logic [31:0] w, input logic s);
      bv[i] = v; bl[i] = l; bx[i] = x; bw[i] = w; bs[i] = s;
   endtask

   task automatic do_start(input logic [31:0] b, input logic ae);
      start  = 1'b1;
      bias   = b;
      act_en = ae;
      @(posedge clk); #1;
      start  = 1'b0;
      bias   = 32'hDEAD_BEEF;
      act_en = ~ae;
   endtask

   task automatic drive_beats();
      for (int i = 0; i < nb; i++) begin
         in_valid = bv[i];
         in_last  = bl[i];
         in_x     = bx[i];
         in_w     = bw[i];
         start    = bs[i];
         if (bs[i]) begin
            #1;
            chk("start_ready_in_accum", 64'(start_ready), 64'd0);
            chk("in_ready_in_accum", 64'(in_ready), 64'd1);
         end
         if (bv[i] && bl[i]) last_cyc = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
   endtask

   task automatic push(input logic [31:0] pre, input logic [31:0] y, input logic d,
                       input logic [15:0] cnt);
      exp_t e;
      e.pre = pre; e.y = y; e.d = d; e.cnt = cnt; e.at = last_cyc + 2;
      sb.push_back(e);
   endtask

   task automatic wait_accept();
      logic ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic one_beat(input logic [31:0] b, input logic ae, input logic [31:0] x,
                           input logic [31:0] w, input logic [31:0] pre, input logic [31:0] y,
                           input logic d);
      do_start(b, ae);
      nb = 1;
      set_beat(0, 1'b1, 1'b1, x, w, 1'b0);
      drive_beats();
      push(pre, y, d, 16'd1);
      wait_accept();
   endtask

   initial begin
      logic ok;
      // Reset state.
      #12;
      chk("rst_start_ready", 64'(start_ready), 64'd1);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pre", 64'(out_pre), 64'd0);
      chk("rst_out_count", 64'(out_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic dot product: 1.0 + 1.5*2.0 + 1.0*1.0 = 5.0.
      do_start(32'h0001_0000, 1'b1);
      nb = 2;
      set_beat(0, 1'b1, 1'b0, 32'h0001_8000, 32'h0002_0000, 1'b0);
      set_beat(1, 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0);
      drive_beats();
      push(32'h0005_0000, 32'h0005_0000, 1'b1, 16'd2);
      wait_accept();

      // Negative pre-activation, relu on then identity.
      one_beat(32'h0, 1'b1, 32'hFFFF_0000, 32'h0002_0000, 32'hFFFE_0000, 32'h0, 1'b0);
      one_beat(32'h0, 1'b0, 32'hFFFF_0000, 32'h0002_0000, 32'hFFFE_0000, 32'hFFFE_0000, 1'b1);

      // Rounding on bit 15.
      one_beat(32'h0, 1'b1, 32'h0000_0001, 32'h0000_8000, 32'h1, 32'h1, 1'b1);
      one_beat(32'h0, 1'b1, 32'h0000_0001, 32'h0000_7FFF, 32'h0, 32'h0, 1'b0);

      // Gaps (one gap carries a stray in_last), start pulses, output backpressure.
      out_ready = 1'b0;
      do_start(32'h0, 1'b1);
      nb = 4;
      set_beat(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
      set_beat(1, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1);
      set_beat(2, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1);
      set_beat(3, 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0);
      drive_beats();
      push(32'h0002_0000, 32'h0002_0000, 1'b1, 16'd2);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("valid_timeout", 64'd0, 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         start = 1'b1;
         #1;
         chk("start_ready_in_done", 64'(start_ready), 64'd0);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      wait_accept();

      // Reset mid-accumulation.
      do_start(32'h0001_0000, 1'b1);
      nb = 3;
      for (int i = 0; i < 3; i++) set_beat(i, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
      drive_beats();
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_start_ready", 64'(start_ready), 64'd1);
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_out_pre", 64'(out_pre), 64'd0);
      chk("abort_out_y", 64'(out_y), 64'd0);
      chk("abort_out_d", 64'(out_d), 64'd0);
      chk("abort_out_count", 64'(out_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      // 3.0 + 2.0*2.0 = 7.0 with nothing left over from the aborted run.
      one_beat(32'h0003_0000, 1'b1, 32'h0002_0000, 32'h0002_0000, 32'h0007_0000,
               32'h0007_0000, 1'b1);

      // Two's-complement wrap.
      one_beat(32'h7FFF_0000, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h8000_0000, 32'h0, 1'b0);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Sequencer for one neuron's forward pass on a single shared Q16.16 multiplier/adder/relu datapath.
- Accepts a bias, then streams (x, w) operand pairs and accumulates sum(w*x)+bias through a one-stage product register.
- Applies relu and returns the activation, the pre-activation and the relu derivative flag to the layer controller over a valid/ready handshake.
- Sits between the layer controller (weight/activation memories) and the training backprop logic, which consumes the derivative flag.

Parameters:
- DW, 32, datapath width; fixed Q16.16 signed.
- CW, 16, width of the beat counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new neuron computation
- start_ready  out  1  high only in IDLE; start accepted when start && start_ready
- bias  in  DW  Q16.16 bias, sampled on start acceptance
- act_en  in  1  sampled on start; 1 = relu applied, 0 = identity
- in_valid  in  1  operand beat valid
- in_ready  out  1  high only in ACCUM
- in_x  in  DW  activation operand
- in_w  in  DW  weight operand
- in_last  in  1  marks final beat of the vector
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_y  out  DW  activation result
- out_pre  out  DW  pre-activation sum
- out_d  out  1  relu derivative (1 if pre > 0, or 1 when act_en = 0)
- out_count  out  CW  number of beats accumulated

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; acc, prod_r, prod_v, count, out_y, out_pre, out_d, out_valid all 0.
  - start_ready = 1 and in_ready = 0 while in IDLE after reset.
- Arithmetic:
  - Product: 64-bit signed a*b, result = z[47:16] + z[15] (round half up on bit 15), truncated to 32 bits.
  - Sum: 32-bit two's-complement wrap; no saturation.
  - relu: y = pre > 0 ? pre : 0; d = pre > 0.
- IDLE:
  - start_ready = 1.
  - On start accept: acc <= bias, act_en latched, count <= 0, prod_v <= 0, go to ACCUM.
- ACCUM:
  - in_ready = 1. Each edge:
    - If prod_v: acc <= acc + prod_r.
    - prod_r <= mult(in_x, in_w), prod_v <= beat (beat = in_valid && in_ready), count <= count + beat.
  - Gaps (in_valid low) are allowed; the pending product is still added.
  - A beat with in_last goes to DRAIN.
  - in_last without in_valid is ignored.
- DRAIN (1 cycle):
  - acc <= acc + prod_r if prod_v; prod_v <= 0; go to DONE.
- DONE:
  - Entry edge registers out_pre = final sum, out_y and out_d per the relu rule / act_en, out_valid = 1.
  - Outputs are stable while out_valid && !out_ready.
  - On accept: out_valid <= 0, state to IDLE.
  - out_count holds the beat count until the next start.
- Latency: last beat accepted in cycle T -> out_valid high in cycle T+2.
- Throughput: one beat per cycle.
- Minimum: a one-beat vector (first beat has in_last) is legal.
- start while not IDLE: ignored, no state change.
- Count wrap at 2^CW: wraps silently.
- Reset mid-operation: immediate return to the reset state; partial sum discarded; no out_valid pulse.

Test Plan:
- Basic dot product: bias=0x00010000 (1.0), beats (x=0x00018000, w=0x00020000), (x=0x00010000, w=0x00010000) with last -> out_pre=0x00050000, out_y=0x00050000, out_d=1, out_count=2, out_valid exactly 2 cycles after the last beat.
- Negative relu: bias=0, one beat x=0xFFFF0000 (-1.0), w=0x00020000, act_en=1 -> out_pre=0xFFFE0000, out_y=0, out_d=0. Repeat with act_en=0 -> out_y=0xFFFE0000, out_d=1.
- Rounding: x=0x00000001, w=0x00008000, bias=0 -> out_pre=0x00000001. x=0x00000001, w=0x00007FFF -> out_pre=0.
- Backpressure and gaps: in_valid toggled 1,0,0,1(last) with x=w=0x00010000; out_ready held low 5 cycles -> out_pre=0x00020000 stable throughout; start pulses during ACCUM/DONE are ignored (start_ready=0).
- Reset mid-ACCUM: rst_n pulsed low after 3 beats -> all outputs 0 and start_ready=1 immediately. A new run then gives the correct result with no residue from the aborted run.
- Wrap: bias=0x7FFF0000, one beat x=w=0x00010000 -> out_pre=0x80000000 (wrapped), out_y=0, out_d=0.
